sync_fifo_ctrl: RTL and testbench

SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

---
 rtl/sync_fifo_ctrl_pkg.sv | 29 ++
 rtl/fifo_ptr.sv | 42 ++++
 rtl/sync_fifo_ctrl.sv | 123 ++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_ctrl_pkg.sv
// ============================================================================
// sync_fifo_ctrl_pkg : shared FIFO sizing constants and helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package sync_fifo_ctrl_pkg;

  // Defaults shared with the storage array and the async-FIFO blocks.
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_PTR_WIDTH  = 3;
  localparam int DEF_AFULL_LVL  = 6;
  localparam int DEF_AEMPTY_LVL = 2;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage : sync_fifo_ctrl_pkg

`default_nettype wire

// File: rtl/fifo_ptr.sv
// ============================================================================
// fifo_ptr : wrap counter with increment and synchronous clear
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_ptr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] ptr
);

  logic [WIDTH-1:0] ptr_q;
  logic [WIDTH-1:0] ptr_d;

  // Natural binary overflow gives the wrap from 2*DEPTH-1 back to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule : fifo_ptr

`default_nettype wire

// File: rtl/sync_fifo_ctrl.sv
// ============================================================================
// sync_fifo_ctrl : pointer/flag controller for a first-word fall-through FIFO
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int PTR_WIDTH  = DEF_PTR_WIDTH,
  parameter int AFULL_LVL  = DEF_AFULL_LVL,
  parameter int AEMPTY_LVL = DEF_AEMPTY_LVL
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  logic                 clr_err,
  output logic                 w_en,
  output logic [PTR_WIDTH-1:0] w_addr,
  output logic                 r_en,
  output logic [PTR_WIDTH-1:0] r_addr,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [PTR_WIDTH:0]   fifo_count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int CW = PTR_WIDTH + 1;

  if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_ctrl: FIFO_DEPTH must be a power of two >= 2");
  end
  if ((1 << PTR_WIDTH) != FIFO_DEPTH) begin : g_bad_ptr_width
    $error("sync_fifo_ctrl: PTR_WIDTH must equal log2(FIFO_DEPTH)");
  end
  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $error("sync_fifo_ctrl: DATA_WIDTH must be at least 1");
  end

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] count;
  fifo_status_t  status;
  logic          push_ok;
  logic          pop_ok;
  logic          overflow_evt;
  logic          underflow_evt;
  logic          overflow_q;
  logic          overflow_d;
  logic          underflow_q;
  logic          underflow_d;

  always_comb begin
    count               = wr_ptr - rd_ptr;
    status.empty        = (wr_ptr == rd_ptr);
    status.full         = (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]) &&
                          (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]);
    status.almost_full  = (count >= CW'(AFULL_LVL));
    status.almost_empty = (count <= CW'(AEMPTY_LVL));
  end

  // No bypass: an empty FIFO never accepts a pop, even alongside a push.
  // rstn gating keeps the strobes quiet while reset is held.
  assign pop_ok  = rstn & pop & ~flush & ~status.empty;
  assign push_ok = rstn & push & ~flush & (~status.full | pop_ok);

  assign overflow_evt  = push & ~flush & status.full & ~pop_ok;
  assign underflow_evt = pop & ~flush & status.empty;

  fifo_ptr #(.WIDTH(CW)) u_wr_ptr (
    .clk  (clk),
    .rstn (rstn),
    .inc  (push_ok),
    .clr  (flush),
    .ptr  (wr_ptr)
  );

  fifo_ptr #(.WIDTH(CW)) u_rd_ptr (
    .clk  (clk),
    .rstn (rstn),
    .inc  (pop_ok),
    .clr  (flush),
    .ptr  (rd_ptr)
  );

  // A fresh error in the clear cycle keeps the flag set.
  always_comb begin
    overflow_d  = overflow_evt  | (overflow_q  & ~clr_err);
    underflow_d = underflow_evt | (underflow_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign w_en         = push_ok;
  assign r_en         = pop_ok;
  assign w_addr       = wr_ptr[PTR_WIDTH-1:0];
  assign r_addr       = rd_ptr[PTR_WIDTH-1:0];
  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign fifo_count   = count;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule : sync_fifo_ctrl

`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
// ============================================================================
// tb_sync_fifo_ctrl : directed bench for sync_fifo_ctrl with a modelled array
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo_ctrl;

  logic       clk;
  logic       rstn;
  logic       push;
  logic       pop;
  logic       flush;
  logic       clr_err;
  logic       w_en;
  logic [2:0] w_addr;
  logic       r_en;
  logic [2:0] r_addr;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       underflow;

  logic [7:0] din;
  logic [7:0] mem [0:7];
  logic [7:0] rdata;

  int checks;
  int errors;

  sync_fifo_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .push         (push),
    .pop          (pop),
    .flush        (flush),
    .clr_err      (clr_err),
    .w_en         (w_en),
    .w_addr       (w_addr),
    .r_en         (r_en),
    .r_addr       (r_addr),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for the parent's storage array.
  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= din;
  end
  assign rdata = mem[r_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic p, input logic q, input logic f, input logic c);
    @(negedge clk);
    push = p; pop = q; flush = f; clr_err = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0;
    rstn = 1'b0; push = 1'b1; pop = 1'b0; flush = 1'b0; clr_err = 1'b0; din = 8'h00;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;

    // Reset state, with push held to show w_en stays gated
    #2;
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_waddr", w_addr, 0);
    chk("rst_raddr", r_addr, 0);
    chk("rst_wen", w_en, 0);
    chk("rst_ren", r_en, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    push = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // Fill
    for (int i = 0; i < 8; i++) begin
      din = 8'hA0 + 8'(i);
      drive(1, 0, 0, 0);
      chk("fill_wen", w_en, 1);
      chk("fill_waddr", w_addr, i);
      tick();
      chk("fill_count", fifo_count, i + 1);
      chk("fill_afull", almost_full, (i + 1 >= 6) ? 1 : 0);
      chk("fill_full", full, (i == 7) ? 1 : 0);
      chk("fill_empty", empty, 0);
    end
    din = 8'hEE;
    drive(1, 0, 0, 0);
    chk("ovf_wen", w_en, 0);
    tick();
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", fifo_count, 8);
    chk("ovf_udf", underflow, 0);

    // Drain
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 0);
      chk("drain_ren", r_en, 1);
      chk("drain_raddr", r_addr, i);
      chk("drain_data", rdata, 8'hA0 + i);
      tick();
      chk("drain_count", fifo_count, 7 - i);
      chk("drain_aempty", almost_empty, (7 - i <= 2) ? 1 : 0);
      chk("drain_empty", empty, (i == 7) ? 1 : 0);
    end
    drive(0, 1, 0, 0);
    chk("udf_ren", r_en, 0);
    tick();
    chk("udf_flag", underflow, 1);
    chk("udf_empty", empty, 1);

    // Wrap: pointers start at 8, so addresses run 0..7 then 0..1
    for (int n = 0; n < 10; n++) begin
      din = 8'h30 + 8'(n);
      drive(1, 0, 0, 0);
      chk("wrap_waddr", w_addr, n % 8);
      tick();
      chk("wrap_count_push", fifo_count, 1);
      drive(0, 1, 0, 0);
      chk("wrap_raddr", r_addr, n % 8);
      chk("wrap_data", rdata, 8'h30 + n);
      tick();
      chk("wrap_count_pop", fifo_count, 0);
    end

    // Clear sticky flags
    drive(0, 0, 0, 1);
    tick();
    chk("clr_ovf", overflow, 0);
    chk("clr_udf", underflow, 0);

    // Simultaneous at full
    for (int i = 0; i < 8; i++) begin
      din = 8'h50 + 8'(i);
      drive(1, 0, 0, 0);
      tick();
    end
    chk("sim_full", full, 1);
    din = 8'h77;
    drive(1, 1, 0, 0);
    chk("simf_wen", w_en, 1);
    chk("simf_ren", r_en, 1);
    chk("simf_data", rdata, 8'h50);
    tick();
    chk("simf_count", fifo_count, 8);
    chk("simf_ovf", overflow, 0);
    for (int i = 1; i < 9; i++) begin
      drive(0, 1, 0, 0);
      chk("simf_order", rdata, (i < 8) ? (8'h50 + i) : 8'h77);
      tick();
    end
    chk("simf_drained", empty, 1);

    // Simultaneous at empty: only the push is taken
    din = 8'h99;
    drive(1, 1, 0, 0);
    chk("sime_wen", w_en, 1);
    chk("sime_ren", r_en, 0);
    tick();
    chk("sime_count", fifo_count, 1);
    chk("sime_udf", underflow, 1);
    drive(0, 1, 0, 0);
    chk("sime_data", rdata, 8'h99);
    tick();
    drive(0, 0, 0, 1);
    tick();
    chk("sime_clr", underflow, 0);

    // Flush with push after 5 pushes
    for (int i = 0; i < 5; i++) begin
      din = 8'h60 + 8'(i);
      drive(1, 0, 0, 0);
      tick();
    end
    chk("fl_pre_count", fifo_count, 5);
    drive(1, 0, 1, 0);
    chk("fl_wen", w_en, 0);
    tick();
    chk("fl_count", fifo_count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_waddr", w_addr, 0);
    drive(0, 1, 0, 1);
    chk("fl_ren", r_en, 0);
    tick();
    chk("fl_udf_wins", underflow, 1);
    drive(0, 0, 1, 0);
    tick();
    chk("fl_keeps_udf", underflow, 1);

    // Async reset at count 4
    for (int i = 0; i < 4; i++) begin
      din = 8'h40 + 8'(i);
      drive(1, 0, 0, 0);
      tick();
    end
    chk("ar_pre_count", fifo_count, 4);
    drive(0, 0, 0, 0);
    #1 rstn = 1'b0;
    #1;
    chk("ar_count", fifo_count, 0);
    chk("ar_empty", empty, 1);
    chk("ar_aempty", almost_empty, 1);
    chk("ar_udf", underflow, 0);
    chk("ar_waddr", w_addr, 0);
    @(negedge clk);
    rstn = 1'b1;
    din = 8'hC3;
    drive(1, 0, 0, 0);
    chk("ar_first_waddr", w_addr, 0);
    chk("ar_first_wen", w_en, 1);
    tick();
    chk("ar_first_count", fifo_count, 1);
    drive(0, 1, 0, 0);
    chk("ar_first_data", rdata, 8'hC3);
    tick();
    drive(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sync_fifo_ctrl

`default_nettype wire
